// File: rtl/mtime_wb_reader.sv
// Tear-free 64-bit mtime fetch over Wishbone (pipelined).
// Reads HI, LO, HI and retries LO/HI when the two HI words differ.
module mtime_wb_reader #(
  parameter int WB_ADDR_WIDTH  = 3,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int LO_ADDR        = 0,
  parameter int HI_ADDR        = 1,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     i_req,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic [63:0]              o_time,
  output logic                     o_err,
  output logic [1:0]               o_err_code,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  input  logic                     i_wb_stall,
  output logic [WB_ADDR_WIDTH-1:0] o_wb_adr,
  output logic                     o_wb_we,
  output logic [WB_DATA_WIDTH-1:0] o_wb_dat,
  output logic [3:0]               o_wb_sel,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic                     i_wb_rty,
  input  logic [WB_DATA_WIDTH-1:0] i_wb_dat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI1,
    S_LO,
    S_HI2,
    S_DONE,
    S_FAIL
  } state_t;

  typedef enum logic {
    PH_REQ,
    PH_WAIT
  } phase_t;

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [WB_ADDR_WIDTH-1:0] A_LO = WB_ADDR_WIDTH'(LO_ADDR);
  localparam logic [WB_ADDR_WIDTH-1:0] A_HI = WB_ADDR_WIDTH'(HI_ADDR);

  localparam logic [1:0] E_BUS   = 2'd1;
  localparam logic [1:0] E_TMO   = 2'd2;
  localparam logic [1:0] E_RETRY = 2'd3;

  state_t                   state_q, state_d;
  phase_t                   ph_q, ph_d;
  logic [WB_DATA_WIDTH-1:0] hi1_q, hi1_d;
  logic [WB_DATA_WIDTH-1:0] lo_q, lo_d;
  logic [RW-1:0]            rcnt_q, rcnt_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [63:0]              time_q, time_d;
  logic [1:0]               code_q, code_d;

  logic in_bus;
  logic resp_slot;
  logic bus_fail;

  assign in_bus = (state_q == S_HI1) ||
                  (state_q == S_LO) ||
                  (state_q == S_HI2);

  // A response counts in WAIT, or in REQ on the accepting edge.
  assign resp_slot = in_bus &&
                     ((ph_q == PH_WAIT) || !i_wb_stall);
  assign bus_fail  = i_wb_err || i_wb_rty;

  assign o_wb_cyc   = in_bus;
  assign o_wb_stb   = in_bus && (ph_q == PH_REQ);
  assign o_wb_adr   = (state_q == S_LO) ? A_LO :
                      (in_bus ? A_HI : '0);
  assign o_wb_we    = 1'b0;
  assign o_wb_dat   = '0;
  assign o_wb_sel   = 4'hF;
  assign o_busy     = in_bus;
  assign o_valid    = (state_q == S_DONE);
  assign o_err      = (state_q == S_FAIL);
  assign o_time     = time_q;
  assign o_err_code = code_q;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      ph_q    <= PH_REQ;
      hi1_q   <= '0;
      lo_q    <= '0;
      rcnt_q  <= '0;
      tmo_q   <= '0;
      time_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      hi1_q   <= hi1_d;
      lo_q    <= lo_d;
      rcnt_q  <= rcnt_d;
      tmo_q   <= tmo_d;
      time_q  <= time_d;
      code_q  <= code_d;
    end
  end

  // Next-state: sequencing, capture, retry and timeout decisions.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    hi1_d   = hi1_q;
    lo_d    = lo_q;
    rcnt_d  = rcnt_q;
    tmo_d   = tmo_q;
    time_d  = time_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          state_d = S_HI1;
          ph_d    = PH_REQ;
          code_d  = '0;
          rcnt_d  = '0;
          tmo_d   = '0;
        end
      end
      S_HI1, S_LO, S_HI2: begin
        if (resp_slot) begin
          if (bus_fail) begin
            state_d = S_FAIL;
            ph_d    = PH_REQ;
            code_d  = E_BUS;
          end else if (i_wb_ack) begin
            ph_d  = PH_REQ;
            tmo_d = '0;
            case (state_q)
              S_HI1: begin
                hi1_d   = i_wb_dat;
                state_d = S_LO;
              end
              S_LO: begin
                lo_d    = i_wb_dat;
                state_d = S_HI2;
              end
              default: begin
                if (i_wb_dat == hi1_q) begin
                  state_d = S_DONE;
                  time_d  = {hi1_q, lo_q};
                end else if (rcnt_q < RMAX) begin
                  hi1_d   = i_wb_dat;
                  rcnt_d  = rcnt_q + 1'b1;
                  state_d = S_LO;
                end else begin
                  state_d = S_FAIL;
                  code_d  = E_RETRY;
                end
              end
            endcase
          end else if (ph_q == PH_REQ) begin
            ph_d  = PH_WAIT;
            tmo_d = '0;
          end else if ((TIMEOUT_CYCLES != 0) &&
                       (tmo_q == TMO_LAST)) begin
            state_d = S_FAIL;
            ph_d    = PH_REQ;
            code_d  = E_TMO;
          end else if (tmo_q != '1) begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = PH_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_mtime_wb_reader.sv
// Directed bench for mtime_wb_reader with a reactive
// Wishbone slave fed from per-test HI/LO word tables.
module tb_mtime_wb_reader;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        i_req = 1'b0;
  logic        o_busy, o_valid, o_err;
  logic [63:0] o_time;
  logic [1:0]  o_err_code;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic        i_wb_stall = 1'b0;
  logic [2:0]  o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_err = 1'b0;
  logic        i_wb_rty = 1'b0;
  logic [31:0] i_wb_dat = '0;

  int vecs = 0;
  int miss = 0;

  logic [31:0] hi_mem [64];
  logic [31:0] lo_mem [64];
  int          hi_rd = 0;
  int          lo_rd = 0;
  logic [2:0]  adr_log [256];
  int          n_acc = 0;
  int          stb_lens [64];
  int          n_stb = 0;
  int          stb_len = 0;
  int          stall_tot = 0;
  int          stall_until = 0;
  bit          mute = 1'b0;
  bit          err_on_lo = 1'b0;
  bit          force_ack = 1'b0;
  bit          pend = 1'b0;
  logic [2:0]  pend_adr = '0;

  always #5 clk = ~clk;

  mtime_wb_reader #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .res       (res),
    .i_req     (i_req),
    .o_busy    (o_busy),
    .o_valid   (o_valid),
    .o_time    (o_time),
    .o_err     (o_err),
    .o_err_code(o_err_code),
    .o_wb_cyc  (o_wb_cyc),
    .o_wb_stb  (o_wb_stb),
    .i_wb_stall(i_wb_stall),
    .o_wb_adr  (o_wb_adr),
    .o_wb_we   (o_wb_we),
    .o_wb_dat  (o_wb_dat),
    .o_wb_sel  (o_wb_sel),
    .i_wb_ack  (i_wb_ack),
    .i_wb_err  (i_wb_err),
    .i_wb_rty  (i_wb_rty),
    .i_wb_dat  (i_wb_dat)
  );

  // Slave: responds one cycle after acceptance, optional stall.
  always @(posedge clk) begin
    #1;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    if (pend && !mute) begin
      if (err_on_lo && pend_adr == 3'd0) begin
        i_wb_err = 1'b1;
      end else begin
        i_wb_ack = 1'b1;
        if (pend_adr == 3'd1) begin
          i_wb_dat = hi_mem[hi_rd];
          hi_rd++;
        end else begin
          i_wb_dat = lo_mem[lo_rd];
          lo_rd++;
        end
        adr_log[n_acc] = pend_adr;
        n_acc++;
      end
    end
    if (force_ack) i_wb_ack = 1'b1;
    i_wb_stall = o_wb_cyc && o_wb_stb &&
                 (stall_tot < stall_until);
    if (i_wb_stall) stall_tot++;
    pend     = o_wb_cyc && o_wb_stb && !i_wb_stall;
    pend_adr = o_wb_adr;
    if (o_wb_stb) begin
      stb_len++;
    end else if (stb_len != 0) begin
      stb_lens[n_stb] = stb_len;
      n_stb++;
      stb_len = 0;
    end
  end

  task automatic run(output int n, output bit v,
                     output bit e, output bit busy1,
                     output logic [1:0] code1);
    @(negedge clk);
    i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    n     = 1;
    busy1 = o_busy;
    code1 = o_err_code;
    while (!o_valid && !o_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    v = o_valid;
    e = o_err;
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({o_wb_cyc, o_wb_stb, o_busy, o_valid, o_err}
        !== 5'b0) begin
      miss++;
      $display("FAIL reset_ctl got %b want 00000",
               {o_wb_cyc, o_wb_stb, o_busy, o_valid, o_err});
    end
    vecs++;
    if ({o_time, o_err_code, o_wb_adr} !== 69'd0) begin
      miss++;
      $display("FAIL reset_data time=%h code=%0d adr=%0d",
               o_time, o_err_code, o_wb_adr);
    end
    res = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n; bit v, e, b1; logic [1:0] c1; int base;
    logic [8:0] seq;
    hi_mem[hi_rd]     = 32'h0000_0001;
    hi_mem[hi_rd + 1] = 32'h0000_0001;
    lo_mem[lo_rd]     = 32'h2345_6789;
    base = n_acc;
    run(n, v, e, b1, c1);
    vecs++;
    if (n !== 7 || v !== 1'b1 || e !== 1'b0) begin
      miss++;
      $display("FAIL basic_lat n=%0d v=%b e=%b want 7 1 0",
               n, v, e);
    end
    vecs++;
    if (o_time !== 64'h0000_0001_2345_6789) begin
      miss++;
      $display("FAIL basic_time got %h want 0000000123456789",
               o_time);
    end
    vecs++;
    if (b1 !== 1'b1 || o_busy !== 1'b0) begin
      miss++;
      $display("FAIL basic_busy c1=%b done=%b want 1 0",
               b1, o_busy);
    end
    seq = {adr_log[base], adr_log[base + 1],
           adr_log[base + 2]};
    vecs++;
    if (n_acc - base !== 3 || seq !== 9'b001_000_001) begin
      miss++;
      $display("FAIL basic_adr cnt=%0d seq=%b want 3 001000001",
               n_acc - base, seq);
    end
    @(negedge clk);
    vecs++;
    if (o_valid !== 1'b0 || o_time !== 64'h1_2345_6789) begin
      miss++;
      $display("FAIL basic_hold v=%b time=%h", o_valid, o_time);
    end
  endtask

  task automatic test_retry();
    int n; bit v, e, b1; logic [1:0] c1;
    hi_mem[hi_rd]     = 32'h5;
    hi_mem[hi_rd + 1] = 32'h6;
    hi_mem[hi_rd + 2] = 32'h6;
    lo_mem[lo_rd]     = 32'hAAAA_AAAA;
    lo_mem[lo_rd + 1] = 32'h0000_0003;
    run(n, v, e, b1, c1);
    vecs++;
    if (n !== 11 || v !== 1'b1) begin
      miss++;
      $display("FAIL retry_lat n=%0d v=%b want 11 1", n, v);
    end
    vecs++;
    if (o_time !== 64'h0000_0006_0000_0003) begin
      miss++;
      $display("FAIL retry_time got %h want 0000000600000003",
               o_time);
    end
  endtask

  task automatic test_exhaust();
    int n; bit v, e, b1; logic [1:0] c1; int hbase;
    for (int i = 0; i < 5; i++) hi_mem[hi_rd + i] = 32'(i + 1);
    for (int i = 0; i < 4; i++) lo_mem[lo_rd + i] = 32'hC0;
    hbase = hi_rd;
    run(n, v, e, b1, c1);
    vecs++;
    if (n !== 19 || e !== 1'b1 || v !== 1'b0) begin
      miss++;
      $display("FAIL exh_lat n=%0d e=%b v=%b want 19 1 0",
               n, e, v);
    end
    vecs++;
    if (o_err_code !== 2'd3 || hi_rd - hbase !== 5) begin
      miss++;
      $display("FAIL exh_code code=%0d hi_reads=%0d want 3 5",
               o_err_code, hi_rd - hbase);
    end
    @(negedge clk);
    vecs++;
    if (o_wb_cyc !== 1'b0 || o_err !== 1'b0 ||
        o_err_code !== 2'd3) begin
      miss++;
      $display("FAIL exh_after cyc=%b err=%b code=%0d",
               o_wb_cyc, o_err, o_err_code);
    end
  endtask

  task automatic test_stall();
    int n; bit v, e, b1; logic [1:0] c1; int sb, ab;
    stall_until = stall_tot + 5;
    sb = n_stb;
    ab = n_acc;
    hi_mem[hi_rd]     = 32'h89AB_CDEF;
    hi_mem[hi_rd + 1] = 32'h89AB_CDEF;
    lo_mem[lo_rd]     = 32'h0123_4567;
    run(n, v, e, b1, c1);
    vecs++;
    if (n !== 12 || v !== 1'b1 ||
        o_time !== 64'h89AB_CDEF_0123_4567) begin
      miss++;
      $display("FAIL stall_res n=%0d v=%b time=%h", n, v, o_time);
    end
    vecs++;
    if (stb_lens[sb] !== 6 || adr_log[ab] !== 3'd1) begin
      miss++;
      $display("FAIL stall_stb len=%0d adr=%0d want 6 1",
               stb_lens[sb], adr_log[ab]);
    end
  endtask

  task automatic test_timeout();
    int n; bit v, e, b1; logic [1:0] c1;
    mute = 1'b1;
    run(n, v, e, b1, c1);
    mute = 1'b0;
    vecs++;
    if (n !== 18 || e !== 1'b1 || o_err_code !== 2'd2) begin
      miss++;
      $display("FAIL tmo n=%0d e=%b code=%0d want 18 1 2",
               n, e, o_err_code);
    end
  endtask

  task automatic test_bus_err();
    int n; bit v, e, b1; logic [1:0] c1;
    err_on_lo = 1'b1;
    hi_mem[hi_rd] = 32'h7;
    run(n, v, e, b1, c1);
    err_on_lo = 1'b0;
    vecs++;
    if (n !== 5 || e !== 1'b1 || o_err_code !== 2'd1) begin
      miss++;
      $display("FAIL buserr n=%0d e=%b code=%0d want 5 1 1",
               n, e, o_err_code);
    end
    @(negedge clk);
    vecs++;
    if (o_err_code !== 2'd1 || o_wb_cyc !== 1'b0) begin
      miss++;
      $display("FAIL buserr_hold code=%0d cyc=%b",
               o_err_code, o_wb_cyc);
    end
    hi_mem[hi_rd]     = 32'hDEAD_0000;
    hi_mem[hi_rd + 1] = 32'hDEAD_0000;
    lo_mem[lo_rd]     = 32'h0000_BEEF;
    run(n, v, e, b1, c1);
    vecs++;
    if (n !== 7 || v !== 1'b1 || c1 !== 2'd0 ||
        o_time !== 64'hDEAD_0000_0000_BEEF) begin
      miss++;
      $display("FAIL after_err n=%0d v=%b code=%0d time=%h",
               n, v, c1, o_time);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit v, e, b1; logic [1:0] c1; bit seen;
    hi_mem[hi_rd] = 32'h11;
    lo_mem[lo_rd] = 32'h22;
    @(negedge clk);
    i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (o_wb_stb !== 1'b1 || o_wb_adr !== 3'd0) begin
      miss++;
      $display("FAIL mid_lo stb=%b adr=%0d want 1 0",
               o_wb_stb, o_wb_adr);
    end
    @(negedge clk);
    res       = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    res       = 1'b0;
    vecs++;
    if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 ||
        o_busy !== 1'b0) begin
      miss++;
      $display("FAIL mid_drop cyc=%b stb=%b busy=%b",
               o_wb_cyc, o_wb_stb, o_busy);
    end
    @(negedge clk);
    force_ack = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid || o_err || o_wb_cyc) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin
      miss++;
      $display("FAIL mid_quiet got activity=%b want 0", seen);
    end
    hi_mem[hi_rd]     = 32'h0000_00AB;
    hi_mem[hi_rd + 1] = 32'h0000_00AB;
    lo_mem[lo_rd]     = 32'h1357_9BDF;
    run(n, v, e, b1, c1);
    vecs++;
    if (n !== 7 || v !== 1'b1 ||
        o_time !== 64'h0000_00AB_1357_9BDF) begin
      miss++;
      $display("FAIL mid_after n=%0d v=%b time=%h",
               n, v, o_time);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_exhaust();
    test_stall();
    test_timeout();
    test_bus_err();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule

// File: doc/mtime_wb_reader.md
Name: mtime_wb_reader

Overview:
- Wishbone pipelined-mode initiator that fetches the 64-bit machine time from the mtime register block as a tear-free snapshot.
- Reads HI, then LO, then HI again, and retries on a HI mismatch (LO carry between accesses).
- Sits between a local consumer (debug/trace, watchdog config logic) and the mtime Wishbone slave.
- Exactly one bus access is outstanding at a time.

Parameters:
- WB_ADDR_WIDTH, 3, width of o_wb_adr
- WB_DATA_WIDTH, 32, bus data width; only 32 is supported
- LO_ADDR, 0, word address of mtime[31:0]
- HI_ADDR, 1, word address of mtime[63:32]
- MAX_RETRY, 3, maximum LO/HI re-read pairs after a HI mismatch
- TIMEOUT_CYCLES, 255, cycles to wait for ack/err per access; 0 disables the timeout

Ports:
- clk  in  1  clock
- res  in  1  synchronous reset, active-high
- i_req  in  1  start a snapshot read; sampled only when o_busy=0
- o_busy  out  1  high from the cycle after an accepted i_req until the cycle o_valid or o_err is pulsed
- o_valid  out  1  one-cycle pulse; o_time is valid
- o_time  out  64  snapshot result; held until the next o_valid
- o_err  out  1  one-cycle pulse on a failed snapshot
- o_err_code  out  2  1=bus err, 2=timeout, 3=retries exhausted; held until the next i_req accept
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- i_wb_stall  in  1  slave stall
- o_wb_adr  out  WB_ADDR_WIDTH  address
- o_wb_we  out  1  tied 0
- o_wb_dat  out  WB_DATA_WIDTH  tied 0
- o_wb_sel  out  4  tied 4'hF
- i_wb_ack  in  1  access acknowledged
- i_wb_err  in  1  access error
- i_wb_rty  in  1  retry request; treated as err
- i_wb_dat  in  WB_DATA_WIDTH  read data

Behaviour:
- Reset values: o_wb_cyc=0, o_wb_stb=0, o_busy=0, o_valid=0, o_err=0, o_err_code=0, o_time=0, o_wb_adr=0. State=IDLE, retry count=0, timeout counter=0.
- Reset asserted mid-transaction:
  - cyc/stb drop the next edge and all state is cleared.
  - No o_valid or o_err pulse is produced.
  - A late ack after reset is ignored.
- States: IDLE, HI1, LO, HI2, DONE, FAIL.
  - Each of HI1, LO and HI2 has two sub-phases: REQ (stb=1) and WAIT (stb=0).
- IDLE:
  - i_req=1 means the next cycle is HI1.REQ with cyc=1, stb=1, adr=HI_ADDR.
  - The error code is cleared and retry count set to 0.
- REQ phase:
  - stb stays high while i_wb_stall=1.
  - On the first edge with stall=0 the address is accepted: next cycle stb=0 and the phase becomes WAIT.
  - The timeout counter is reset at acceptance.
- WAIT phase:
  - On i_wb_ack, i_wb_dat is captured into the state's register (hi1, lo or hi2).
  - An ack arriving in the same cycle as acceptance (zero-wait slave) is honoured; the phase goes straight to the next state.
  - i_wb_err or i_wb_rty goes to FAIL with code 1. Err has priority over a simultaneous ack.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with no response, go to FAIL with code 2.
- Read sequence: HI1 → LO → HI2, cyc held high continuously across all accesses.
- Check after HI2:
  - hi2==hi1: go to DONE with o_time={hi1,lo}.
  - Mismatch with retry count < MAX_RETRY: hi1 := hi2, count += 1, go to LO.REQ (re-read LO, then HI2).
  - Mismatch with count == MAX_RETRY: go to FAIL with code 3.
- DONE: one cycle. cyc=0, o_valid=1, o_busy=0 in that cycle, then IDLE.
- FAIL: one cycle. cyc=0, o_err=1, o_busy=0, then IDLE.
- i_req in DONE or FAIL is ignored.
- Latency with a zero-wait, zero-stall slave (ack the cycle after acceptance):
  - req at cycle 0 → o_valid at cycle 7.
  - Each extra stall or wait cycle adds 1.
  - Each retry adds 4.
- Unexpected ack in IDLE, REQ or DONE is ignored.
- The timeout counter saturates and never wraps.

Test Plan:
- Slave with mtime=0x0000_0001_2345_6789, no stall, ack next cycle; pulse i_req → adr sequence 1,0,1; o_valid at cycle 7; o_time=0x0000_0001_2345_6789; o_err=0.
- Slave HI reads 0x5 then 0x6 (carry), LO second read 0x0000_0003, HI third read 0x6 → exactly one retry; o_time=0x0000_0006_0000_0003; o_valid at cycle 11.
- HI changes on every read with MAX_RETRY=3 → 4 HI2 reads; o_err pulse, o_err_code=3, no o_valid, cyc low afterwards.
- Stall held 5 cycles on the first access → stb and adr=HI_ADDR stable for 6 cycles; o_valid at cycle 12; data correct.
- Slave never acks, TIMEOUT_CYCLES=16 → o_err with code 2 after 16 WAIT cycles. Repeat with i_wb_err on the LO access → code 1 immediately; a following i_req succeeds.
- Assert res in the cycle after LO acceptance → cyc=stb=0 next edge; no o_valid or o_err; the late ack is ignored; a new i_req completes normally.
